// File: rtl/iir_y_requant.sv
// Purpose : requantize the IIR adder-tree sum S[3,23] to y[n] S[1,15] (round half-up, saturate),
//           hold the y[n-1]/y[n-2] feedback taps and count saturation events.
// Latency : 2 cycles input accept -> out_valid; 1 sample/cycle. Backpressure: both stages stall on out_valid && !out_ready.
module iir_y_requant #(
    parameter int IN_INT   = 3,
    parameter int IN_FRAC  = 23,
    parameter int OUT_INT  = 1,
    parameter int OUT_FRAC = 15,
    parameter int CNT_W    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [IN_INT+IN_FRAC:0]       in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [OUT_INT+OUT_FRAC:0]     out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_INT+OUT_FRAC:0]     y_d1,
    output logic [OUT_INT+OUT_FRAC:0]     y_d2,
    output logic                          ovf_flag,
    output logic [CNT_W-1:0]              ovf_cnt,
    input  logic                          ovf_clr
);

    localparam int IN_W  = IN_INT + IN_FRAC + 1;
    localparam int OUT_W = OUT_INT + OUT_FRAC + 1;
    // Number of fractional bits dropped by the requantization.
    localparam int D     = IN_FRAC - OUT_FRAC;
    // Width of the rounded value: (IN_W+1)-bit sum shifted right by D.
    // Always at least OUT_W+1, so the saturation test has a guard bit.
    localparam int RW    = IN_W + 1 - D;

    localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Stage 1 (rounded value) registers
    logic              s1_valid_q, s1_valid_d;
    logic [RW-1:0]     s1_r_q,     s1_r_d;

    // Stage 2 (saturated output) registers
    logic              out_valid_q, out_valid_d;
    logic [OUT_W-1:0]  out_data_q,  out_data_d;
    logic              sat_event_q, sat_event_d;

    // Feedback taps
    logic [OUT_W-1:0]  y_d1_q, y_d1_d;
    logic [OUT_W-1:0]  y_d2_q, y_d2_d;

    // Overflow monitor
    logic              ovf_flag_q, ovf_flag_d;
    logic [CNT_W-1:0]  ovf_cnt_q,  ovf_cnt_d;

    // Combinational helpers
    logic              adv;
    logic              xfer_out;
    logic [IN_W:0]     rnd_one;
    logic [IN_W:0]     rnd_sum;
    logic [RW-1:0]     r_rnd;
    logic              rnd_frac_unused;
    logic              pos_ovf;
    logic              neg_ovf;
    logic [OUT_W-1:0]  sat_val;

    // The whole pipe moves together: it advances whenever the output slot is empty or being drained.
    assign adv      = ~out_valid_q | out_ready;
    assign xfer_out = out_valid_q & out_ready;

    // Round half-up: sign-extend by one bit so adding the half-LSB can never wrap, then drop D bits.
    always_comb begin
        rnd_one        = '0;
        rnd_one[D-1]   = 1'b1;
        rnd_sum        = {in_data[IN_W-1], in_data} + rnd_one;
    end

    assign r_rnd           = rnd_sum[IN_W:D];
    // The discarded fraction bits only matter through the carry they produce.
    assign rnd_frac_unused = ^rnd_sum[D-1:0];

    // Saturate: the rounded value fits S[OUT_INT,OUT_FRAC] only if all bits above the output sign agree with it.
    always_comb begin
        pos_ovf = ~s1_r_q[RW-1] &  (|s1_r_q[RW-2:OUT_W-1]);
        neg_ovf =  s1_r_q[RW-1] & ~(&s1_r_q[RW-2:OUT_W-1]);
        sat_val = s1_r_q[OUT_W-1:0];
        if (pos_ovf) begin
            sat_val = SAT_MAX;
        end else if (neg_ovf) begin
            sat_val = SAT_MIN;
        end
    end

    // Next-state for pipeline, feedback taps and overflow monitor.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_r_d      = s1_r_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        sat_event_d = sat_event_q;
        y_d1_d      = y_d1_q;
        y_d2_d      = y_d2_q;
        ovf_flag_d  = ovf_flag_q;
        ovf_cnt_d   = ovf_cnt_q;

        if (adv) begin
            s1_valid_d  = in_valid;
            s1_r_d      = r_rnd;
            out_valid_d = s1_valid_q;
            out_data_d  = sat_val;
            sat_event_d = s1_valid_q & (pos_ovf | neg_ovf);
        end

        // Taps shift only when y[n] actually leaves the stage, so stalls never skew the recursion.
        if (xfer_out) begin
            y_d2_d = y_d1_q;
            y_d1_d = out_data_q;
        end

        // Events are counted at output transfer so a stalled sample is counted exactly once; clear wins.
        if (ovf_clr) begin
            ovf_flag_d = 1'b0;
            ovf_cnt_d  = '0;
        end else if (xfer_out && sat_event_q) begin
            ovf_flag_d = 1'b1;
            if (ovf_cnt_q != CNT_MAX) begin
                ovf_cnt_d = ovf_cnt_q + CNT_ONE;
            end
        end
    end

    // State registers with synchronous reset; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_r_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_event_q <= 1'b0;
            y_d1_q      <= '0;
            y_d2_q      <= '0;
            ovf_flag_q  <= 1'b0;
            ovf_cnt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_r_q      <= s1_r_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            sat_event_q <= sat_event_d;
            y_d1_q      <= y_d1_d;
            y_d2_q      <= y_d2_d;
            ovf_flag_q  <= ovf_flag_d;
            ovf_cnt_q   <= ovf_cnt_d;
        end
    end

    assign in_ready  = adv;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign y_d1      = y_d1_q;
    assign y_d2      = y_d2_q;
    assign ovf_flag  = ovf_flag_q;
    assign ovf_cnt   = ovf_cnt_q;

endmodule
